// File: rtl/sg_spi_rx.sv
// sg_spi_rx: SPI responder for the sine-generator serial link.
// Oversamples FSYNC/SCLK/SDATA on clk, assembles 16-bit MSB-first words and
// decodes control, FREQ0/1 and PHASE0/1 writes into shadow registers.
// Optional macro SGRX_WORD_COUNT_EN builds a saturating accepted-word counter;
// without it word_count is tied to zero.
module sg_spi_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] CTRL_RST    = 16'h0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SGFSYNC,
  input  logic        SGSPI_CLK,
  input  logic        SGDIN,
  output logic        word_dv,
  output logic [15:0] word_data,
  output logic [15:0] ctrl_reg,
  output logic        dds_reset,
  output logic [27:0] freq0,
  output logic [27:0] freq1,
  output logic [11:0] phase0,
  output logic [11:0] phase1,
  output logic        freq_update,
  output logic        frame_err,
  output logic [15:0] word_count
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 4;

  // ST_WAIT holds off after reset until FSYNC is seen high, so a frame that
  // was already running when reset arrived is never picked up half-way.
  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] fsync_q, sclk_q, sdin_q;
  logic                   fsync_d1, sclk_d1;
  logic                   fsync_s, sclk_s, sdin_s;
  logic                   fsync_fall_c, fsync_rise_c, sclk_fall_c;
  logic                   shift_en_c, frame_err_c, word_done_c;

  logic [WORD_W-1:0]      shreg;
  logic [CNT_W-1:0]       bit_cnt;
  logic [WORD_W-1:0]      word_c;
  logic [13:0]            d_c;

  logic                   lsb_pending;
  logic                   pend_tgt;
  logic [13:0]            pend_lsb;

  assign fsync_s = fsync_q[SYNC_STAGES-1];
  assign sclk_s  = sclk_q[SYNC_STAGES-1];
  assign sdin_s  = sdin_q[SYNC_STAGES-1];

  assign fsync_fall_c = fsync_d1 & ~fsync_s;
  assign fsync_rise_c = ~fsync_d1 & fsync_s;
  assign sclk_fall_c  = sclk_d1 & ~sclk_s;

  assign word_c = {shreg[WORD_W-2:0], sdin_s};
  assign d_c    = word_c[13:0];

  assign dds_reset = ctrl_reg[8];

  // Equal-depth synchronizers plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsync_q  <= '0;
      sclk_q   <= '1;
      sdin_q   <= '0;
      fsync_d1 <= 1'b0;
      sclk_d1  <= 1'b1;
    end else begin
      fsync_q  <= {fsync_q[SYNC_STAGES-2:0], SGFSYNC};
      sclk_q   <= {sclk_q[SYNC_STAGES-2:0], SGSPI_CLK};
      sdin_q   <= {sdin_q[SYNC_STAGES-2:0], SGDIN};
      fsync_d1 <= fsync_s;
      sclk_d1  <= sclk_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_WAIT;
    else       state <= state_nxt;
  end

  // Frame next-state; an SCLK fall coinciding with the FSYNC rise is dropped.
  always_comb begin
    state_nxt   = state;
    shift_en_c  = 1'b0;
    frame_err_c = 1'b0;
    case (state)
      ST_WAIT: begin
        if (fsync_s) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (fsync_fall_c) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (fsync_rise_c) begin
          state_nxt   = ST_IDLE;
          frame_err_c = (bit_cnt != '0);
        end else if (sclk_fall_c) begin
          shift_en_c = 1'b1;
        end
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  assign word_done_c = shift_en_c && (bit_cnt == CNT_W'(15));

  // Bit shifter and counter; counter wraps after 16 bits so frames may carry several words.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en_c) begin
      shreg   <= word_c;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end else if (state != ST_SHIFT || fsync_rise_c) begin
      bit_cnt <= '0;
    end
  end

  // Word output and register decode, both effective in the word_dv cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_dv     <= 1'b0;
      word_data   <= '0;
      ctrl_reg    <= CTRL_RST;
      freq0       <= '0;
      freq1       <= '0;
      phase0      <= '0;
      phase1      <= '0;
      freq_update <= 1'b0;
      frame_err   <= 1'b0;
      lsb_pending <= 1'b0;
      pend_tgt    <= 1'b0;
      pend_lsb    <= '0;
    end else begin
      word_dv     <= 1'b0;
      freq_update <= 1'b0;
      frame_err   <= frame_err_c;
      if (word_done_c) begin
        word_dv   <= 1'b1;
        word_data <= word_c;
        case (word_c[15:14])
          2'b00: begin
            ctrl_reg    <= word_c;
            lsb_pending <= 1'b0;
          end
          2'b01, 2'b10: begin
            // word_c[15] is 0 for FREQ0 and 1 for FREQ1
            if (ctrl_reg[13]) begin
              if (lsb_pending && (pend_tgt == word_c[15])) begin
                if (word_c[15]) freq1 <= {d_c, pend_lsb};
                else            freq0 <= {d_c, pend_lsb};
                freq_update <= 1'b1;
                lsb_pending <= 1'b0;
              end else begin
                pend_lsb    <= d_c;
                pend_tgt    <= word_c[15];
                lsb_pending <= 1'b1;
              end
            end else begin
              if (word_c[15]) begin
                if (ctrl_reg[12]) freq1[27:14] <= d_c;
                else              freq1[13:0]  <= d_c;
              end else begin
                if (ctrl_reg[12]) freq0[27:14] <= d_c;
                else              freq0[13:0]  <= d_c;
              end
              freq_update <= 1'b1;
            end
          end
          default: begin
            if (word_c[13]) phase1 <= word_c[11:0];
            else            phase0 <= word_c[11:0];
          end
        endcase
      end
    end
  end

`ifdef SGRX_WORD_COUNT_EN
  logic [15:0] word_cnt_q;

  // Saturating count of accepted words; a control word with bit 8 set clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt_q <= '0;
    end else if (word_done_c && (word_c[15:14] == 2'b00) && word_c[8]) begin
      word_cnt_q <= '0;
    end else if (word_done_c && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_q <= word_cnt_q + 16'd1;
    end
  end

  assign word_count = word_cnt_q;
`else
  assign word_count = 16'h0000;
`endif

endmodule

// File: tb/tb_sg_spi_rx.sv
// Bench for sg_spi_rx: table of frames with hand-computed register state,
// plus a reset-during-frame sequence.
module tb_sg_spi_rx;

  logic        clk;
  logic        reset;
  logic        SGFSYNC;
  logic        SGSPI_CLK;
  logic        SGDIN;
  logic        word_dv;
  logic [15:0] word_data;
  logic [15:0] ctrl_reg;
  logic        dds_reset;
  logic [27:0] freq0;
  logic [27:0] freq1;
  logic [11:0] phase0;
  logic [11:0] phase1;
  logic        freq_update;
  logic        frame_err;
  logic [15:0] word_count;

  int total = 0;
  int bad   = 0;
  int n_dv  = 0;
  int n_fu  = 0;
  int n_fe  = 0;

  sg_spi_rx dut (
    .clk        (clk),
    .reset      (reset),
    .SGFSYNC    (SGFSYNC),
    .SGSPI_CLK  (SGSPI_CLK),
    .SGDIN      (SGDIN),
    .word_dv    (word_dv),
    .word_data  (word_data),
    .ctrl_reg   (ctrl_reg),
    .dds_reset  (dds_reset),
    .freq0      (freq0),
    .freq1      (freq1),
    .phase0     (phase0),
    .phase1     (phase1),
    .freq_update(freq_update),
    .frame_err  (frame_err),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse-cycle counters; tests take differences around each frame.
  always @(negedge clk) begin
    if (word_dv)     n_dv <= n_dv + 1;
    if (freq_update) n_fu <= n_fu + 1;
    if (frame_err)   n_fe <= n_fe + 1;
  end

  typedef struct {
    logic [47:0] data;
    int          nb;
    int          e_dv;
    logic [15:0] e_word;
    logic [15:0] e_ctrl;
    logic [27:0] e_f0;
    logic [27:0] e_f1;
    logic [11:0] e_p0;
    logic [11:0] e_p1;
    int          e_fu;
    int          e_fe;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    SGDIN = b;
    repeat (6) @(negedge clk);
    SGSPI_CLK = 1'b0;
    repeat (6) @(negedge clk);
    SGSPI_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [47:0] d, input int nb);
    SGFSYNC = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nb; i++) send_bit(d[nb-1-i]);
    repeat (6) @(negedge clk);
    SGFSYNC = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int dv0, fu0, fe0;

    vt[0]  = '{48'h2100,         16, 1, 16'h2100, 16'h2100, 28'h0000000, 28'h0000000, 12'h000, 12'h000, 0, 0};
    vt[1]  = '{48'h69FE4000C000, 48, 3, 16'hC000, 16'h2100, 28'h00029FE, 28'h0000000, 12'h000, 12'h000, 1, 0};
    vt[2]  = '{48'h2000,         16, 1, 16'h2000, 16'h2000, 28'h00029FE, 28'h0000000, 12'h000, 12'h000, 0, 0};
    vt[3]  = '{48'h155,           9, 0, 16'h2000, 16'h2000, 28'h00029FE, 28'h0000000, 12'h000, 12'h000, 0, 1};
    vt[4]  = '{48'h2100,         16, 1, 16'h2100, 16'h2100, 28'h00029FE, 28'h0000000, 12'h000, 12'h000, 0, 0};
    vt[5]  = '{48'h1000,         16, 1, 16'h1000, 16'h1000, 28'h00029FE, 28'h0000000, 12'h000, 12'h000, 0, 0};
    vt[6]  = '{48'h4001,         16, 1, 16'h4001, 16'h1000, 28'h00069FE, 28'h0000000, 12'h000, 12'h000, 1, 0};
    vt[7]  = '{48'h2100,         16, 1, 16'h2100, 16'h2100, 28'h00069FE, 28'h0000000, 12'h000, 12'h000, 0, 0};
    vt[8]  = '{48'h4123,         16, 1, 16'h4123, 16'h2100, 28'h00069FE, 28'h0000000, 12'h000, 12'h000, 0, 0};
    vt[9]  = '{48'h2100,         16, 1, 16'h2100, 16'h2100, 28'h00069FE, 28'h0000000, 12'h000, 12'h000, 0, 0};
    vt[10] = '{48'h4000,         16, 1, 16'h4000, 16'h2100, 28'h00069FE, 28'h0000000, 12'h000, 12'h000, 0, 0};
    vt[11] = '{48'h80008005,     32, 2, 16'h8005, 16'h2100, 28'h00069FE, 28'h0014000, 12'h000, 12'h000, 1, 0};
    vt[12] = '{48'hD123E0AB,     32, 2, 16'hE0AB, 16'h2100, 28'h00069FE, 28'h0014000, 12'h123, 12'h0AB, 0, 0};
    vt[13] = '{48'h00007FFF,     32, 2, 16'h7FFF, 16'h0000, 28'h0007FFF, 28'h0014000, 12'h123, 12'h0AB, 1, 0};

    reset     = 1'b1;
    SGFSYNC   = 1'b1;
    SGSPI_CLK = 1'b1;
    SGDIN     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    chk("rst_ctrl",  32'(ctrl_reg),  32'h0100);
    chk("rst_dds",   32'(dds_reset), 32'h1);
    chk("rst_freq0", 32'(freq0),     32'h0);
    chk("rst_freq1", 32'(freq1),     32'h0);
    chk("rst_word",  32'(word_data), 32'h0);
    chk("rst_wcnt",  32'(word_count), 32'h0);
    chk("rst_pulses", 32'(n_dv + n_fu + n_fe), 32'h0);

    for (int k = 0; k < 14; k++) begin
      dv0 = n_dv; fu0 = n_fu; fe0 = n_fe;
      send_frame(vt[k].data, vt[k].nb);
      chk($sformatf("v%0d_dv", k),    32'(n_dv - dv0),   32'(vt[k].e_dv));
      chk($sformatf("v%0d_word", k),  32'(word_data),    32'(vt[k].e_word));
      chk($sformatf("v%0d_ctrl", k),  32'(ctrl_reg),     32'(vt[k].e_ctrl));
      chk($sformatf("v%0d_dds", k),   32'(dds_reset),    32'(vt[k].e_ctrl[8]));
      chk($sformatf("v%0d_f0", k),    32'(freq0),        32'(vt[k].e_f0));
      chk($sformatf("v%0d_f1", k),    32'(freq1),        32'(vt[k].e_f1));
      chk($sformatf("v%0d_p0", k),    32'(phase0),       32'(vt[k].e_p0));
      chk($sformatf("v%0d_p1", k),    32'(phase1),       32'(vt[k].e_p1));
      chk($sformatf("v%0d_fu", k),    32'(n_fu - fu0),   32'(vt[k].e_fu));
      chk($sformatf("v%0d_fe", k),    32'(n_fe - fe0),   32'(vt[k].e_fe));
    end

    // Reset in the middle of a frame: the rest of that frame must be ignored.
    SGFSYNC = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_ctrl",  32'(ctrl_reg), 32'h0100);
    chk("mid_rst_freq0", 32'(freq0),    32'h0);
    chk("mid_rst_phase1", 32'(phase1),  32'h0);
    dv0 = n_dv; fe0 = n_fe;
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    repeat (6) @(negedge clk);
    SGFSYNC = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_dv",  32'(n_dv - dv0), 32'h0);
    chk("mid_rst_no_fe",  32'(n_fe - fe0), 32'h0);
    chk("mid_rst_ctrl_kept", 32'(ctrl_reg), 32'h0100);

    dv0 = n_dv;
    send_frame(48'h2100, 16);
    chk("post_rst_dv",   32'(n_dv - dv0), 32'h1);
    chk("post_rst_ctrl", 32'(ctrl_reg),   32'h2100);
    chk("post_rst_dds",  32'(dds_reset),  32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sg_spi_rx.md
Name: sg_spi_rx

Overview:
- SPI receiver for the sine-generator serial link (FSYNC/SDATA/SCLK, 16-bit words, MSB first). It implements the responder end of the sine-generator command protocol.
- Oversamples the link on the system clock, assembles words and decodes control, FREQ0/1 and PHASE0/1 writes into shadow registers.
- Used as an in-FPGA emulation target for the sine-gen configuration path and as a bus monitor for debug.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on FSYNC/SCLK/SDATA (min 2); all three use equal depth to keep them aligned.
- CTRL_RST, 16'h0100, control register value after reset (RESET bit set).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- SGFSYNC  input  1  frame select, active low
- SGSPI_CLK  input  1  serial clock, idles high
- SGDIN  input  1  serial data, sampled on SCLK falling edge
- word_dv  output  1  one-cycle pulse, word_data valid
- word_data  output  16  last complete word
- ctrl_reg  output  16  current control word
- dds_reset  output  1  ctrl_reg[8]
- freq0  output  28  FREQ0 register
- freq1  output  28  FREQ1 register
- phase0  output  12  PHASE0 register
- phase1  output  12  PHASE1 register
- freq_update  output  1  one-cycle pulse when freq0 or freq1 changes
- frame_err  output  1  one-cycle pulse on a short word
- word_count  output  16  accepted-word counter (see Optional Feature)

Behaviour:
- Reset values:
  - ctrl_reg = CTRL_RST, so dds_reset = 1.
  - freq0, freq1, phase0, phase1, word_data, word_count = 0.
  - All pulses = 0.
  - Bit counter = 0; lsb_pending = 0.
  - Reset mid-frame discards partial bits. The receiver then waits for FSYNC high before accepting a new frame.
- Input sync and edge detection:
  - Inputs pass through SYNC_STAGES flops.
  - SCLK falling edge = previous synced value 1, current value 0.
  - Input timing requirement: SCLK high and low phases each >= SYNC_STAGES+2 clk periods.
- Frame/bit state machine:
  - IDLE: FSYNC high. Bit counter = 0.
  - IDLE -> SHIFT: on synced FSYNC falling.
  - SHIFT: on each SCLK fall, shift synced SDATA into a 16-bit register (MSB first) and increment the 4-bit counter.
  - On the 16th bit, counter wraps to 0 and state stays SHIFT. Multiple words per frame are allowed (e.g. 3 words in one 6-byte frame).
  - SHIFT -> IDLE: on FSYNC rise.
  - If FSYNC rises with counter != 0: pulse frame_err, discard partial word, leave registers unchanged.
  - An SCLK fall in the same cycle as the FSYNC rise is ignored.
- Word completion:
  - word_dv and word_data update on the cycle after the 16th SCLK fall is detected.
  - Register decode takes effect in the same cycle as word_dv.
- Decode on word w:
  - w[15:14]=00: ctrl_reg <= w; lsb_pending <= 0.
  - w[15:14]=01 targets FREQ0; w[15:14]=10 targets FREQ1. Data field d = w[13:0]. Write depends on B28 = ctrl_reg[13] and HLB = ctrl_reg[12]:
    - B28=1, lsb_pending=0: latch d as pending LSB, record target; lsb_pending <= 1; no output change.
    - B28=1, lsb_pending=1, same target: target <= {d, pending LSB}; pulse freq_update; lsb_pending <= 0.
    - B28=1, lsb_pending=1, other target: discard old pending LSB; treat d as new LSB for the new target.
    - B28=0, HLB=0: target[13:0] <= d. B28=0, HLB=1: target[27:14] <= d. Either case pulses freq_update.
  - w[15:13]=110: phase0 <= w[11:0]. w[15:13]=111: phase1 <= w[11:0]. Neither affects lsb_pending.
- lsb_pending persists across frame boundaries and is cleared only by a control word or reset.

Optional Feature:
- Macro SGRX_WORD_COUNT_EN.
- Defined: word_count increments on every word_dv and saturates at 16'hFFFF. It clears on reset or on any control word with bit 8 set.
- Undefined: word_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset: assert reset 3 cycles -> ctrl_reg=16'h0100, dds_reset=1, freq0=freq1=0, no pulses.
- Frame 16'h2100 -> one word_dv, word_data=16'h2100, ctrl_reg=16'h2100, dds_reset=1.
- After 16'h2100, one 6-byte frame 16'h69FE,16'h4000,16'hC000:
  - no freq_update after the first word;
  - after the second word freq0=28'h00029FE and freq_update pulses once;
  - phase0=0, three word_dv pulses.
- Frame 16'h2000 -> dds_reset=0, freq0 unchanged.
- FSYNC rises after 9 SCLK falls -> frame_err pulse, no word_dv, registers unchanged; next frame 16'h2100 decodes correctly.
- ctrl 16'h1000 (B28=0, HLB=1) then 16'h4001 -> freq0[27:14]=1, freq0[13:0] unchanged, freq_update pulses. Separately, in B28=1 mode, 16'h4123 then 16'h2100 then 16'h4000 -> 16'h4000 is treated as a fresh LSB and freq0 is not updated.
